// File: rtl/hack_isa_pkg.sv
// Hack ISA constants: instruction bit positions, datapath widths and the ALU control bundle.
package hack_isa_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 15;

    localparam int unsigned INSTR_C = 15;
    localparam int unsigned A_SEL   = 12;
    localparam int unsigned C_ZX    = 11;
    localparam int unsigned C_NX    = 10;
    localparam int unsigned C_ZY    = 9;
    localparam int unsigned C_NY    = 8;
    localparam int unsigned C_F     = 7;
    localparam int unsigned C_NO    = 6;
    localparam int unsigned D_A     = 5;
    localparam int unsigned D_D     = 4;
    localparam int unsigned D_M     = 3;
    localparam int unsigned J_LT    = 2;
    localparam int unsigned J_EQ    = 1;
    localparam int unsigned J_GT    = 0;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    // Field order of alu_ctrl_t matches instruction bits 11..6.
    function automatic alu_ctrl_t decode_alu_ctrl(logic [DATA_W-1:0] instr);
        return alu_ctrl_t'(instr[C_ZX:C_NO]);
    endfunction

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: optional zero/invert of each operand, add or and, optional output invert.
module hack_alu
    import hack_isa_pkg::*;
(
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    input  alu_ctrl_t         ctrl_i,
    output logic [DATA_W-1:0] out_o,
    output logic              zr_o,
    output logic              ng_o
);

    logic [DATA_W-1:0] x_z, x_n, y_z, y_n, res;

    always_comb begin
        x_z   = ctrl_i.zx ? '0 : x_i;
        x_n   = ctrl_i.nx ? ~x_z : x_z;
        y_z   = ctrl_i.zy ? '0 : y_i;
        y_n   = ctrl_i.ny ? ~y_z : y_z;
        res   = ctrl_i.f ? (x_n + y_n) : (x_n & y_n);
        out_o = ctrl_i.no ? ~res : res;
        zr_o  = (out_o == '0);
        ng_o  = out_o[DATA_W-1];
    end

endmodule

// File: rtl/hack_cpu_core.sv
// Single-cycle Hack CPU: A/D/PC registers, instruction decode, jump resolution and RAM write port.
module hack_cpu_core #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 15,
    parameter logic [14:0] RESET_PC = 15'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instruction,
    input  logic [DATA_W-1:0] inM,
    input  logic              stall,
    output logic [DATA_W-1:0] outM,
    output logic              writeM,
    output logic [ADDR_W-1:0] addressM,
    output logic [ADDR_W-1:0] pc
);

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic                   is_c;
    logic [DATA_W-1:0]      alu_y;
    logic [DATA_W-1:0]      alu_out;
    logic                   alu_zr;
    logic                   alu_ng;
    logic                   taken;
    hack_isa_pkg::alu_ctrl_t alu_ctrl;

    assign is_c     = instruction[hack_isa_pkg::INSTR_C];
    assign alu_y    = instruction[hack_isa_pkg::A_SEL] ? inM : a_q;
    assign alu_ctrl = hack_isa_pkg::decode_alu_ctrl(instruction);

    hack_alu u_alu (
        .x_i    (d_q),
        .y_i    (alu_y),
        .ctrl_i (alu_ctrl),
        .out_o  (alu_out),
        .zr_o   (alu_zr),
        .ng_o   (alu_ng)
    );

    assign taken = is_c & ((instruction[hack_isa_pkg::J_LT] & alu_ng)
                         | (instruction[hack_isa_pkg::J_EQ] & alu_zr)
                         | (instruction[hack_isa_pkg::J_GT] & ~alu_ng & ~alu_zr));

    // Jump target and memory address both use the pre-edge A, even when A is also a destination.
    always_comb begin
        a_d  = a_q;
        d_d  = d_q;
        pc_d = taken ? a_q[ADDR_W-1:0] : pc_q + 1'b1;
        if (!is_c) begin
            a_d = {{(DATA_W-ADDR_W){1'b0}}, instruction[ADDR_W-1:0]};
        end else begin
            if (instruction[hack_isa_pkg::D_A]) a_d = alu_out;
            if (instruction[hack_isa_pkg::D_D]) d_d = alu_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            d_q  <= '0;
            pc_q <= RESET_PC;
        end else if (!stall) begin
            a_q  <= a_d;
            d_q  <= d_d;
            pc_q <= pc_d;
        end
    end

    assign outM     = alu_out;
    assign writeM   = is_c & instruction[hack_isa_pkg::D_M] & ~stall & ~rst;
    assign addressM = a_q[ADDR_W-1:0];
    assign pc       = pc_q;

    logic unused_bits;
    assign unused_bits = ^{instruction[14:13], a_q[DATA_W-1:ADDR_W]};

endmodule

// File: tb/tb_hack_cpu_core.sv
// Directed-vector bench for hack_cpu_core with an expectation queue and a negedge monitor.
module tb_hack_cpu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instruction;
    logic [15:0] inM;
    logic        stall;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM;
    logic [14:0] pc;

    hack_cpu_core dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .inM         (inM),
        .stall       (stall),
        .outM        (outM),
        .writeM      (writeM),
        .addressM    (addressM),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        string nm;
        int    e_pc;
        int    e_addr;
        int    e_out;
        logic  e_wr;
    } exp_t;

    typedef struct {
        string       nm;
        logic [14:0] addr;
        logic [15:0] data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   cyc_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [15:0] c_ins(logic a, logic [5:0] comp, logic [2:0] dst,
                                          logic [2:0] jmp);
        return {3'b111, a, comp, dst, jmp};
    endfunction

    function automatic logic [15:0] a_ins(int unsigned v);
        logic [15:0] r;
        r = 16'(v);
        r[15] = 1'b0;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    // Drive one cycle of inputs and queue what the monitor should see in that cycle (-1 = skip).
    task automatic step(string nm, logic [15:0] ins, logic [15:0] inm, logic stl, logic rs,
                        int e_pc, int e_addr, int e_out, int e_wa);
        exp_t e;
        wr_t  w;
        instruction = ins;
        inM         = inm;
        stall       = stl;
        rst         = rs;
        e.cyc    = cyc_cnt;
        e.nm     = nm;
        e.e_pc   = e_pc;
        e.e_addr = e_addr;
        e.e_out  = e_out;
        e.e_wr   = (e_wa >= 0);
        exp_q.push_back(e);
        if (e_wa >= 0) begin
            w.nm   = nm;
            w.addr = e_wa[14:0];
            w.data = e_out[15:0];
            wr_q.push_back(w);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
            e = exp_q.pop_front();
            chk({e.nm, "_writeM"}, {31'b0, writeM}, {31'b0, e.e_wr});
            if (e.e_pc >= 0)   chk({e.nm, "_pc"}, {17'b0, pc}, 32'(e.e_pc));
            if (e.e_addr >= 0) chk({e.nm, "_addressM"}, {17'b0, addressM}, 32'(e.e_addr));
            if (e.e_out >= 0)  chk({e.nm, "_outM"}, {16'b0, outM}, 32'(e.e_out));
        end
        if (writeM === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                         addressM, outM);
            end else begin
                w = wr_q.pop_front();
                chk({w.nm, "_wr_addr"}, {17'b0, addressM}, {17'b0, w.addr});
                chk({w.nm, "_wr_data"}, {16'b0, outM}, {16'b0, w.data});
            end
        end
    end

    logic [15:0] m_neg1, m_eq_d, d_only, a_only, zero_jmp;

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        instruction = '0;
        inM         = '0;
        m_neg1   = c_ins(1'b0, 6'b111010, 3'b001, 3'b000);
        m_eq_d   = c_ins(1'b0, 6'b001100, 3'b001, 3'b000);
        d_only   = c_ins(1'b0, 6'b001100, 3'b000, 3'b000);
        a_only   = c_ins(1'b0, 6'b110000, 3'b000, 3'b000);
        zero_jmp = c_ins(1'b0, 6'b101010, 3'b000, 3'b111);
        @(posedge clk);
        #1;

        // Reset for two cycles with a store instruction present: no write may escape.
        step("rst0", m_neg1, 16'h0, 1'b0, 1'b1, -1, -1, -1, -1);
        step("rst1", m_neg1, 16'h0, 1'b0, 1'b1, 0, 0, -1, -1);

        // @2, D=A, @3, D=D+A, @0, M=D
        step("at2",      a_ins(2), 16'h0, 1'b0, 1'b0, 0, 0, -1, -1);
        step("d_eq_a",   c_ins(1'b0, 6'b110000, 3'b010, 3'b000), 16'h0, 1'b0, 1'b0, 1, 2, 2, -1);
        step("at3",      a_ins(3), 16'h0, 1'b0, 1'b0, 2, -1, -1, -1);
        step("d_plus_a", c_ins(1'b0, 6'b000010, 3'b010, 3'b000), 16'h0, 1'b0, 1'b0, 3, 3, 5, -1);
        step("at0",      a_ins(0), 16'h0, 1'b0, 1'b0, 4, -1, -1, -1);
        step("m_eq_d",   m_eq_d, 16'h0, 1'b0, 1'b0, 5, 0, 5, 0);

        // Conditional jumps
        step("d_zero",    c_ins(1'b0, 6'b101010, 3'b010, 3'b000), 16'h0, 1'b0, 1'b0, 6, -1, 0, -1);
        step("at100",     a_ins(100), 16'h0, 1'b0, 1'b0, 7, -1, -1, -1);
        step("jeq_taken", c_ins(1'b0, 6'b001100, 3'b000, 3'b010), 16'h0, 1'b0, 1'b0, 8, 100, 0, -1);
        step("d_one",     c_ins(1'b0, 6'b111111, 3'b010, 3'b000), 16'h0, 1'b0, 1'b0, 100, -1, 1, -1);
        step("at100b",    a_ins(100), 16'h0, 1'b0, 1'b0, 101, -1, -1, -1);
        step("jeq_not",   c_ins(1'b0, 6'b001100, 3'b000, 3'b010), 16'h0, 1'b0, 1'b0, 102, 100, 1, -1);
        step("d_neg1",    c_ins(1'b0, 6'b111010, 3'b010, 3'b000), 16'h0, 1'b0, 1'b0, 103, -1,
             16'hFFFF, -1);
        step("at100c",    a_ins(100), 16'h0, 1'b0, 1'b0, 104, -1, -1, -1);
        step("jlt_taken", c_ins(1'b0, 6'b001100, 3'b000, 3'b100), 16'h0, 1'b0, 1'b0, 105, 100,
             16'hFFFF, -1);

        // AM=A+1;JMP uses the old A for both the write address and the jump target.
        step("at7",        a_ins(7), 16'h0, 1'b0, 1'b0, 100, -1, -1, -1);
        step("am_inc_jmp", c_ins(1'b0, 6'b110111, 3'b101, 3'b111), 16'h0, 1'b0, 1'b0, 101, 7, 8, 7);

        // Three stalled cycles on M=-1, then the single real write.
        for (int i = 0; i < 3; i++) begin
            step($sformatf("stall%0d", i), m_neg1, 16'h0, 1'b1, 1'b0, 7, 8, 16'hFFFF, -1);
        end
        step("stall_rel", m_neg1, 16'h0, 1'b0, 1'b0, 7, 8, 16'hFFFF, 8);

        // D=M, then jump to 0x42 and reset there while stalled.
        step("d_eq_m",  c_ins(1'b1, 6'b110000, 3'b010, 3'b000), 16'h1234, 1'b0, 1'b0, 8, 8,
             16'h1234, -1);
        step("at42",    a_ins(16'h42), 16'h0, 1'b0, 1'b0, 9, -1, -1, -1);
        step("jmp42",   zero_jmp, 16'h0, 1'b0, 1'b0, 10, 16'h42, 0, -1);
        step("rst_mid", m_eq_d, 16'h0, 1'b1, 1'b1, 16'h42, 16'h42, 16'h1234, -1);
        step("post_rst_d", d_only, 16'h0, 1'b1, 1'b0, 0, 0, 0, -1);
        step("post_rst_a", a_only, 16'h0, 1'b1, 1'b0, 0, 0, 0, -1);

        // PC wrap from 0x7FFF
        step("at7fff",   a_ins(16'h7FFF), 16'h0, 1'b0, 1'b0, 0, -1, -1, -1);
        step("jmp7fff",  zero_jmp, 16'h0, 1'b0, 1'b0, 1, 16'h7FFF, 0, -1);
        step("at5_wrap", a_ins(5), 16'h0, 1'b0, 1'b0, 16'h7FFF, 16'h7FFF, -1, -1);
        step("wrapped",  d_only, 16'h0, 1'b0, 1'b0, 0, 5, 0, -1);

        @(negedge clk);
        chk("pending_checks", 32'(exp_q.size()), 32'd0);
        chk("pending_writes", 32'(wr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
